// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode decoder.
//   - Prefix bytes (E0 extended, F0 break, E1 Pause) and the discard-code test.
//   - Modifier scancodes tracked by the decoder.
//   - ps2_event_t: one decoded key event as stored in the event FIFO.
//   - ps2_state_e: decoder FSM states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard status/response bytes; never part of a key sequence.
  localparam logic [7:0] PS2_DISC_00 = 8'h00;
  localparam logic [7:0] PS2_DISC_AA = 8'hAA;
  localparam logic [7:0] PS2_DISC_EE = 8'hEE;
  localparam logic [7:0] PS2_DISC_FA = 8'hFA;
  localparam logic [7:0] PS2_DISC_FC = 8'hFC;
  localparam logic [7:0] PS2_DISC_FD = 8'hFD;
  localparam logic [7:0] PS2_DISC_FE = 8'hFE;
  localparam logic [7:0] PS2_DISC_FF = 8'hFF;

  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_ALT    = 8'h11;

  // Bytes following E1 that are swallowed before the Pause event is emitted.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } ps2_state_e;

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      PS2_DISC_00, PS2_DISC_AA, PS2_DISC_EE, PS2_DISC_FA,
      PS2_DISC_FC, PS2_DISC_FD, PS2_DISC_FE, PS2_DISC_FF: is_discard = 1'b1;
      default:                                            is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO of ps2_event_t.
//   clk, reset : clock, asynchronous active-high reset (FIFO empties)
//   push, wdata: write request and data; accepted unless full without a same-cycle pop
//   pop        : remove head entry (ignored when empty)
//   rdata      : head entry, valid while empty=0
//   full, empty: occupancy flags
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t wdata,
  input  logic       pop,
  output ps2_event_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  ps2_event_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: reassembles E0/F0/E1 byte sequences into key events,
// queues them in an FWFT FIFO and tracks modifier key state.
//   clk, reset          : clock, asynchronous active-high reset
//   rx_done_tick,rx_data: one received byte per strobe
//   ev_valid/ev_ready   : event handshake; ev_code/ev_ext/ev_break describe the head event
//   mods                : [0] L-shift [1] R-shift [2] ctrl [3] alt, 1 = held
//   clr_overflow        : clears overflow (a same-cycle drop wins)
//   overflow            : sticky, an event was dropped because the FIFO was full
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [3:0] mods,
  input  logic       clr_overflow,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC);

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0] mods_q, mods_d;
  logic overflow_q, overflow_d;

  logic emit, drop, pop, fifo_full, fifo_empty;
  ps2_event_t ev_d, head;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    emit    = 1'b0;
    ev_d    = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (rx_done_tick) begin
      tmo_d = '0;
      if (is_discard(rx_data)) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == PS2_EXT) begin
              state_d = StExt;
            end else if (rx_data == PS2_BRK) begin
              state_d = StBrk;
            end else if (rx_data == PS2_PAUSE) begin
              state_d = StPause;
              skip_d  = PAUSE_SKIP;
            end else begin
              emit = 1'b1;
            end
          end
          StExt: begin
            if (rx_data == PS2_BRK) begin
              state_d = StExtBrk;
            end else if (rx_data != PS2_EXT) begin
              emit     = 1'b1;
              ev_d.ext = 1'b1;
              state_d  = StIdle;
            end
          end
          StBrk: begin
            if (rx_data != PS2_BRK) begin
              emit     = 1'b1;
              ev_d.brk = 1'b1;
              state_d  = StIdle;
            end
          end
          StExtBrk: begin
            if (rx_data != PS2_BRK) begin
              emit     = 1'b1;
              ev_d.ext = 1'b1;
              ev_d.brk = 1'b1;
              state_d  = StIdle;
            end
          end
          StPause: begin
            skip_d = skip_q - 3'd1;
            // Last byte of the 8-byte Pause sequence.
            if (skip_q == 3'd1) begin
              emit      = 1'b1;
              ev_d.ext  = 1'b1;
              ev_d.code = PS2_PAUSE;
              state_d   = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle) begin
      if (tmo_q == TMO_LAST) begin
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Modifiers follow every emitted event, including ones the FIFO drops.
  always_comb begin
    mods_d = mods_q;
    if (emit) begin
      if (ev_d.code == MOD_LSHIFT && !ev_d.ext) mods_d[0] = !ev_d.brk;
      if (ev_d.code == MOD_RSHIFT && !ev_d.ext) mods_d[1] = !ev_d.brk;
      if (ev_d.code == MOD_CTRL)                mods_d[2] = !ev_d.brk;
      if (ev_d.code == MOD_ALT)                 mods_d[3] = !ev_d.brk;
    end
  end

  assign pop  = !fifo_empty && ev_ready;
  assign drop = emit && fifo_full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      tmo_q      <= '0;
      mods_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      mods_q     <= mods_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (emit),
    .wdata(ev_d),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Outputs read as zero while empty so stale FIFO contents never show.
  assign ev_valid = !fifo_empty;
  assign ev_code  = fifo_empty ? 8'h00 : head.code;
  assign ev_ext   = fifo_empty ? 1'b0 : head.ext;
  assign ev_break = fifo_empty ? 1'b0 : head.brk;
  assign mods     = mods_q;
  assign overflow = overflow_q;

endmodule
